// File: rtl/quiz_score_counter_if.sv
// Button inputs and score/round status outputs of the quiz score counter.
interface quiz_score_counter_if;
   logic       start;
   logic       answer_valid;
   logic       answer_correct;
   logic [6:0] score;
   logic [3:0] q_index;
   logic       busy;
   logic       done;

   modport master (
      output start, answer_valid, answer_correct,
      input  score, q_index, busy, done
   );

   modport slave (
      input  start, answer_valid, answer_correct,
      output score, q_index, busy, done
   );
endinterface

// File: rtl/quiz_score_counter.sv
// Quiz round controller: synchronises the push-buttons, counts answers in a
// fixed-length round and accumulates a saturating score.
module quiz_score_counter #(
   parameter int NUM_Q     = 10,
   parameter int POINTS    = 10,
   parameter int MAX_SCORE = 100
) (
   input logic                  clk,
   input logic                  nRST,
   quiz_score_counter_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PLAY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] PTS8  = 8'(POINTS);
   localparam logic [7:0] MAX8  = 8'(MAX_SCORE);
   localparam logic [3:0] LASTQ = 4'(NUM_Q);

   logic [2:0] start_sync_q, start_sync_d;
   logic [2:0] ans_sync_q,   ans_sync_d;
   logic [1:0] corr_sync_q,  corr_sync_d;
   logic [1:0] state_q,      state_d;
   logic [6:0] score_q,      score_d;
   logic [3:0] q_index_q,    q_index_d;
   logic       busy_q,       busy_d;
   logic       done_q,       done_d;

   logic       start_p;
   logic       ans_p;
   logic       correct;
   logic [7:0] sum;
   logic [3:0] q_next;

   // [0]=s1, [1]=s2, [2]=edge-detect flop
   assign start_sync_d = {start_sync_q[1:0], bus.start};
   assign ans_sync_d   = {ans_sync_q[1:0],   bus.answer_valid};
   assign corr_sync_d  = {corr_sync_q[0],    bus.answer_correct};

   assign start_p = start_sync_q[1] & ~start_sync_q[2];
   assign ans_p   = ans_sync_q[1]   & ~ans_sync_q[2];
   assign correct = corr_sync_q[1];

   // 8-bit sum so the ceiling compare never sees a 7-bit wrap
   assign sum    = {1'b0, score_q} + PTS8;
   assign q_next = q_index_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      q_index_d = q_index_q;
      case (state_q)
         IDLE: begin
            if (start_p) begin
               score_d   = '0;
               q_index_d = '0;
               state_d   = PLAY;
            end
         end
         PLAY: begin
            if (start_p) begin
               score_d   = '0;
               q_index_d = '0;
            end else if (ans_p) begin
               q_index_d = q_next;
               if (correct) begin
                  score_d = (sum > MAX8) ? MAX8[6:0] : sum[6:0];
               end
               if (q_next == LASTQ) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (start_p) begin
               score_d   = '0;
               q_index_d = '0;
               state_d   = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == PLAY);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         start_sync_q <= '0;
         ans_sync_q   <= '0;
         corr_sync_q  <= '0;
         state_q      <= IDLE;
         score_q      <= '0;
         q_index_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         start_sync_q <= start_sync_d;
         ans_sync_q   <= ans_sync_d;
         corr_sync_q  <= corr_sync_d;
         state_q      <= state_d;
         score_q      <= score_d;
         q_index_q    <= q_index_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.score   = score_q;
   assign bus.q_index = q_index_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_quiz_score_counter.sv
// Scoreboard bench for quiz_score_counter: a default instance and a 15-question
// instance for the saturation case, each tracked by a behavioural model.
module tb_quiz_score_counter;

   logic clk  = 1'b0;
   logic nRST = 1'b0;
   always #5 clk = ~clk;

   quiz_score_counter_if if0();
   quiz_score_counter_if if1();

   quiz_score_counter #(.NUM_Q(10), .POINTS(10), .MAX_SCORE(100)) dut (
      .clk(clk), .nRST(nRST), .bus(if0)
   );
   quiz_score_counter #(.NUM_Q(15), .POINTS(10), .MAX_SCORE(100)) dut15 (
      .clk(clk), .nRST(nRST), .bus(if1)
   );

   typedef struct {
      int    sel;
      int    score;
      int    q;
      int    busy;
      int    done;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // model: st 0=IDLE 1=PLAY 2=DONE
   int m_score[2];
   int m_q[2];
   int m_st[2];
   int nq[2];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_score[i] = 0;
         m_q[i]     = 0;
         m_st[i]    = 0;
      end
   endfunction

   function automatic void apply(int sel, bit sp, bit ap, bit corr);
      if (sp) begin
         m_score[sel] = 0;
         m_q[sel]     = 0;
         m_st[sel]    = 1;
      end else if (ap && m_st[sel] == 1) begin
         m_q[sel]++;
         if (corr) m_score[sel] = (m_score[sel] + 10 > 100) ? 100 : m_score[sel] + 10;
         if (m_q[sel] == nq[sel]) m_st[sel] = 2;
      end
   endfunction

   task automatic set_btn(int sel, bit st, bit av, bit ac);
      if (sel == 0) begin
         if0.start = st; if0.answer_valid = av; if0.answer_correct = ac;
      end else begin
         if1.start = st; if1.answer_valid = av; if1.answer_correct = ac;
      end
   endtask

   task automatic read_out(int sel, output logic [31:0] sc, output logic [31:0] q,
                           output logic [31:0] b, output logic [31:0] d);
      if (sel == 0) begin
         sc = 32'(if0.score); q = 32'(if0.q_index); b = 32'(if0.busy); d = 32'(if0.done);
      end else begin
         sc = 32'(if1.score); q = 32'(if1.q_index); b = 32'(if1.busy); d = 32'(if1.done);
      end
   endtask

   task automatic check_now(int sel, string tag);
      logic [31:0] sc, q, b, d;
      read_out(sel, sc, q, b, d);
      chk({tag, "_score"}, sc, m_score[sel]);
      chk({tag, "_q"},     q,  m_q[sel]);
      chk({tag, "_busy"},  b,  32'(m_st[sel] == 1));
      chk({tag, "_done"},  d,  32'(m_st[sel] == 2));
   endtask

   task automatic push_exp(int sel, string tag);
      exp_t e;
      e.sel = sel; e.score = m_score[sel]; e.q = m_q[sel];
      e.busy = (m_st[sel] == 1) ? 1 : 0; e.done = (m_st[sel] == 2) ? 1 : 0; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      logic [31:0] sc, q, b, d;
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         read_out(e.sel, sc, q, b, d);
         chk({e.tag, "_score"}, sc, e.score);
         chk({e.tag, "_q"},     q,  e.q);
         chk({e.tag, "_busy"},  b,  e.busy);
         chk({e.tag, "_done"},  d,  e.done);
      end
   endtask

   // Drives one press; outputs must be unchanged after edge k+1 and updated after k+2.
   task automatic press(int sel, bit sp, bit ap, bit corr, int hold, string tag);
      int pre_score, pre_q;
      logic [31:0] sc, q, b, d;
      set_btn(sel, 1'b0, 1'b0, corr);
      repeat (2) @(negedge clk);
      pre_score = m_score[sel];
      pre_q     = m_q[sel];
      set_btn(sel, sp, ap, corr);
      apply(sel, sp, ap, corr);
      push_exp(sel, tag);
      repeat (2) @(negedge clk);
      read_out(sel, sc, q, b, d);
      chk({tag, "_lat_score"}, sc, pre_score);
      chk({tag, "_lat_q"},     q,  pre_q);
      @(negedge clk);
      sb_check();
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check_now(sel, {tag, "_hold"});
      end
      set_btn(sel, 1'b0, 1'b0, corr);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit mixed[10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
      nq[0] = 10;
      nq[1] = 15;
      model_reset();
      set_btn(0, 1'b0, 1'b0, 1'b0);
      set_btn(1, 1'b0, 1'b0, 1'b0);
      #1;
      check_now(0, "por");
      check_now(1, "por15");
      repeat (3) @(negedge clk);
      nRST = 1'b1;
      @(negedge clk);

      press(0, 0, 1, 1, 0, "idle_ans");

      press(0, 1, 0, 0, 0, "start_a");
      for (int i = 0; i < 10; i++) press(0, 0, 1, 1, 0, $sformatf("allc%0d", i));
      press(0, 0, 1, 1, 0, "done_ign");

      press(0, 1, 0, 0, 0, "start_b");
      for (int i = 0; i < 10; i++) press(0, 0, 1, mixed[i], 0, $sformatf("mix%0d", i));
      press(0, 0, 1, 1, 0, "mix_done_ign");

      press(0, 1, 0, 0, 0, "start_c");
      press(0, 0, 1, 1, 47, "held");
      press(0, 0, 1, 1, 0, "repress");
      press(0, 0, 1, 1, 0, "to30");
      press(0, 0, 1, 1, 0, "to40");
      press(0, 1, 1, 1, 0, "restart_prio");
      press(0, 0, 1, 1, 0, "pre_rst");

      @(posedge clk);
      #3;
      nRST = 1'b0;
      #1;
      model_reset();
      check_now(0, "mid_rst");
      check_now(1, "mid_rst15");
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      @(negedge clk);
      press(0, 0, 1, 1, 0, "post_rst_idle_ans");

      nRST = 1'b0;
      set_btn(0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      apply(0, 1, 0, 0);
      push_exp(0, "start_thru_rst");
      repeat (3) @(negedge clk);
      sb_check();
      repeat (5) @(negedge clk);
      check_now(0, "start_thru_rst_hold");
      set_btn(0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      press(1, 1, 0, 0, 0, "start15");
      for (int i = 0; i < 15; i++) press(1, 0, 1, 1, 0, $sformatf("sat%0d", i));

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
